conware_life_engine: RTL and testbench

//  Game-of-Life generation engine. Consumes a WIDTH*HEIGHT 1-bit grid from the pixel-to-grid

---
 rtl/conware_life_engine.sv | 156 +++++++++++++++
 tb/tb_conware_life_engine.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/conware_life_engine.sv
// conware_life_engine
//   Game-of-Life (B3/S23) generation engine. Accepts one WIDTH*HEIGHT grid,
//   evolves it for the requested number of generations at one row per clock,
//   then presents the result until the downstream stage takes it.
//   Only one grid is in flight at a time.
//
//   Build option: CONWARE_WRAP_EN
//     Defined:   the grid is a torus (edges wrap around).
//     Undefined: cells outside the grid count as dead.
//
// Ports
//   clk          clock
//   rstn         synchronous reset, active-low
//   in_data      input grid, cell (r,c) = bit r*WIDTH+c, 1 = alive
//   in_valid     in_data/generations valid
//   in_ready     engine idle, accepts a grid
//   generations  number of generations to compute, sampled with in_data
//   out_data     result grid, same bit mapping
//   out_valid    out_data valid
//   out_ready    downstream accepts out_data
//   static_out   final generation equalled its predecessor (qualified by out_valid)
module conware_life_engine #(
  parameter int WIDTH  = 4,
  parameter int HEIGHT = 4,
  parameter int GEN_W  = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [WIDTH*HEIGHT-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [GEN_W-1:0]        generations,
  output logic [WIDTH*HEIGHT-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    static_out
);

  localparam int N  = WIDTH * HEIGHT;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t             state, state_d;
  logic [N-1:0]       cur;
  logic [N-1:0]       nxt;
  logic [N-1:0]       nxt_full;
  logic [WIDTH-1:0]   row_new;
  logic [RW-1:0]      row;
  logic [GEN_W-1:0]   gen_left;
  logic               last_row;

  // Cell lookup with out-of-grid coordinates resolved by the border mode.
  function automatic logic cell_at(input logic [N-1:0] g, input int r, input int c);
    int           rr;
    int           cc;
    logic [N-1:0] sh;
`ifdef CONWARE_WRAP_EN
    rr = (r < 0) ? HEIGHT - 1 : ((r >= HEIGHT) ? 0 : r);
    cc = (c < 0) ? WIDTH - 1  : ((c >= WIDTH)  ? 0 : c);
`else
    if (r < 0 || r >= HEIGHT || c < 0 || c >= WIDTH) return 1'b0;
    rr = r;
    cc = c;
`endif
    sh = g >> unsigned'(rr * WIDTH + cc);
    return sh[0];
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign last_row  = (row == RW'(HEIGHT - 1));

  // Next-generation values for the row currently being processed.
  always_comb begin
    logic [3:0] cnt;
    row_new = '0;
    cnt     = '0;
    for (int unsigned c = 0; c < WIDTH; c++) begin
      cnt = '0;
      for (int unsigned k = 0; k < 9; k++) begin
        if (k != 4)
          cnt = cnt + {3'b000, cell_at(cur, int'(row) + int'(k / 3) - 1,
                                            int'(c) + int'(k % 3) - 1)};
      end
      row_new[c] = (cnt == 4'd3) | (cell_at(cur, int'(row), int'(c)) & (cnt == 4'd2));
    end
  end

  // nxt with the row being computed this cycle merged in, so the final
  // row of a generation is available on the same edge cur is replaced.
  always_comb begin
    nxt_full = nxt;
    for (int unsigned r = 0; r < HEIGHT; r++) begin
      if (row == RW'(r)) nxt_full[r*WIDTH +: WIDTH] = row_new;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (in_valid) state_d = (generations == '0) ? DONE : COMPUTE;
      COMPUTE: if (last_row && gen_left == GEN_W'(1)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cur        <= '0;
      nxt        <= '0;
      row        <= '0;
      gen_left   <= '0;
      out_data   <= '0;
      static_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cur      <= in_data;
            gen_left <= generations;
            row      <= '0;
            if (generations == '0) begin
              out_data   <= in_data;
              static_out <= 1'b0;
            end
          end
        end
        COMPUTE: begin
          nxt <= nxt_full;
          if (last_row) begin
            cur        <= nxt_full;
            row        <= '0;
            gen_left   <= gen_left - GEN_W'(1);
            static_out <= (nxt_full == cur);
            if (gen_left == GEN_W'(1)) out_data <= nxt_full;
          end else begin
            row <= row + RW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conware_life_engine.sv
// Self-checking bench for conware_life_engine (4x4 grid, 8-bit generation count).
// A transaction-level model predicts handshakes, latency and results; a
// negedge process compares the DUT against it every cycle, and directed
// tests add hand-computed literal expectations.
module tb_conware_life_engine;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int GW = 8;
  localparam int N  = W * H;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [N-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [GW-1:0] generations = '0;
  logic [N-1:0]  out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          static_out;

  int unsigned total = 0;
  int unsigned passed = 0;
  int unsigned cyc = 0;
  int unsigned acc = 0;

  conware_life_engine #(.WIDTH(W), .HEIGHT(H), .GEN_W(GW)) dut (
    .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .generations(generations), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .static_out(static_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [N-1:0] step(input logic [N-1:0] g);
    logic [N-1:0] nx;
    int cnt, rr, cc;
    nx = '0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (dr != 0 || dc != 0) begin
`ifdef CONWARE_WRAP_EN
              rr = (r + dr + H) % H;
              cc = (c + dc + W) % W;
              cnt += int'(g[rr*W+cc]);
`else
              rr = r + dr;
              cc = c + dc;
              if (rr >= 0 && rr < H && cc >= 0 && cc < W) cnt += int'(g[rr*W+cc]);
`endif
            end
        nx[r*W+c] = (cnt == 3) || (g[r*W+c] && cnt == 2);
      end
    return nx;
  endfunction

  function automatic logic [N-1:0] evolve(input logic [N-1:0] g, input int gens);
    logic [N-1:0] x;
    x = g;
    for (int i = 0; i < gens; i++) x = step(x);
    return x;
  endfunction

  function automatic logic is_static(input logic [N-1:0] g, input int gens);
    logic [N-1:0] p;
    if (gens == 0) return 1'b0;
    p = evolve(g, gens - 1);
    return step(p) == p;
  endfunction

  logic         m_live = 1'b0;
  logic         m_valid = 1'b0;
  int unsigned  m_wait = 0;
  logic [N-1:0] m_res = '0;
  logic         m_stat = 1'b0;
  logic         m_in_ready;
  assign m_in_ready = !m_valid && (m_wait == 0);

  always @(posedge clk) begin
    if (!rstn) begin
      m_live  <= 1'b1;
      m_valid <= 1'b0;
      m_wait  <= 0;
    end else if (m_live) begin
      if (m_valid && out_ready) m_valid <= 1'b0;
      if (m_wait != 0) begin
        if (m_wait == 1) m_valid <= 1'b1;
        m_wait <= m_wait - 1;
      end
      if (m_in_ready && in_valid) begin
        m_res  <= evolve(in_data, int'(generations));
        m_stat <= is_static(in_data, int'(generations));
        if (generations == 0) m_valid <= 1'b1;
        else                  m_wait  <= int'(generations) * H;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("in_ready", 32'(in_ready), 32'(m_in_ready));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        chk("out_data", 32'(out_data), 32'(m_res));
        chk("static_out", 32'(static_out), 32'(m_stat));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic send(input logic [N-1:0] d, input int g);
    in_data = d;
    generations = GW'(g);
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !in_ready; i++) begin @(posedge clk); #1; end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    acc = cyc;
    in_valid = 1'b0;
  endtask

  // Latency counts clock edges from the accept edge to the edge that raises
  // out_valid; a zero-generation grid is valid right after the accept edge.
  task automatic wait_valid(input logic [N-1:0] d, input logic s, input int lat);
    for (int i = 0; i < 1100 && !out_valid; i++) begin @(posedge clk); #1; end
    chk("out_valid_wait", 32'(out_valid), 32'd1);
    chk("latency", cyc - acc, 32'(lat));
    chk("result", 32'(out_data), 32'(d));
    chk("static", 32'(static_out), 32'(s));
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    // model pins
    chk("model_blinker", 32'(evolve(16'h0070, 1)), 32'h0222);
    chk("model_block", 32'(is_static(16'h0033, 3)), 32'd1);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // blinker
    send(16'h0070, 1); wait_valid(16'h0222, 1'b0, 4); take();
    send(16'h0070, 2); wait_valid(16'h0070, 1'b0, 8); take();
    // block is a still life
    send(16'h0033, 3); wait_valid(16'h0033, 1'b1, 12); take();
    // zero generations passes the grid through
    send(16'hA5A5, 0); wait_valid(16'hA5A5, 1'b0, 0); take();
    // full grid
`ifdef CONWARE_WRAP_EN
    send(16'hFFFF, 1); wait_valid(16'h0000, 1'b0, 4); take();
    send(16'h0007, 1); wait_valid(16'h2022, 1'b0, 4); take();
`else
    send(16'hFFFF, 1); wait_valid(16'h9009, 1'b0, 4); take();
    send(16'h0007, 1); wait_valid(16'h0022, 1'b0, 4); take();
`endif
    // maximum generation count
    send(16'h0033, 255); wait_valid(16'h0033, 1'b1, 1020); take();

    // backpressure: result held, new grid refused until released
    send(16'h0070, 1); wait_valid(16'h0222, 1'b0, 4);
    in_data = 16'h0033;
    generations = GW'(1);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", 32'(out_data), 32'h0222);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    acc = cyc;
    in_valid = 1'b0;
    wait_valid(16'h0033, 1'b1, 4); take();

    // reset in the middle of a computation
    send(16'h0070, 5);
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_data", 32'(out_data), 32'd0);
    chk("abort_static", 32'(static_out), 32'd0);
    repeat (40) @(posedge clk);
    #1;
    chk("abort_quiet", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
